// File: rtl/bus_arbiter_driver.sv
// Shared tri-state bus driver: round-robin arbitration among NUM_SRC sources,
// registered one-hot grant, high-Z turnaround gap between owners and a keeper register.
module bus_arbiter_driver #(
    parameter int WIDTH      = 8,
    parameter int NUM_SRC    = 4,
    parameter int TURNAROUND = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         req,
    input  logic [NUM_SRC*WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]           bus_out,
    output logic [NUM_SRC-1:0]         grant,
    output logic                       bus_valid,
    output logic [WIDTH-1:0]           hold_data,
    output logic [$clog2(NUM_SRC)-1:0] owner
);

    localparam int OW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t               state_r;
    logic [NUM_SRC-1:0]   grant_r;
    logic                 bus_valid_r;
    logic [OW-1:0]        owner_r;
    logic [OW-1:0]        rr_ptr_r;
    logic [2:0]           cnt_r;
    logic [WIDTH-1:0]     hold_r;

    logic [OW:0]          pick_s;
    logic                 pick_hit_s;
    logic [OW-1:0]        pick_idx_s;
    logic [OW-1:0]        ptr_next_s;
    logic [NUM_SRC-1:0]   onehot_s;
    logic [WIDTH-1:0]     drive_s;

    // First set request at or above the pointer, wrapping; the lowest offset wins.
    function automatic logic [OW:0] rr_pick(input logic [NUM_SRC-1:0] r,
                                            input logic [OW-1:0]      p);
        logic [OW:0] res;
        int          idx;
        res = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            idx = (int'(p) + i) % NUM_SRC;
            if (r[idx]) begin
                res = {1'b1, OW'(idx)};
            end
        end
        return res;
    endfunction

    assign pick_s     = rr_pick(req, rr_ptr_r);
    assign pick_hit_s = pick_s[OW];
    assign pick_idx_s = pick_s[OW-1:0];
    assign ptr_next_s = (pick_idx_s == OW'(NUM_SRC - 1)) ? '0 : pick_idx_s + OW'(1);
    assign onehot_s   = {{(NUM_SRC-1){1'b0}}, 1'b1} << pick_idx_s;

    // Bus data is muxed by the registered grant so source data changes pass straight through.
    always_comb begin
        drive_s = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (grant_r[k]) begin
                drive_s = drive_s | data_in[k*WIDTH +: WIDTH];
            end else begin
                drive_s = drive_s;
            end
        end
    end

    assign bus_out   = bus_valid_r ? drive_s : {WIDTH{1'bz}};
    assign grant     = grant_r;
    assign bus_valid = bus_valid_r;
    assign hold_data = hold_r;
    assign owner     = owner_r;

    // Arbitration / ownership state machine.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            grant_r     <= '0;
            bus_valid_r <= 1'b0;
            owner_r     <= '0;
            rr_ptr_r    <= '0;
            cnt_r       <= 3'd0;
            hold_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pick_hit_s) begin
                        grant_r     <= onehot_s;
                        bus_valid_r <= 1'b1;
                        owner_r     <= pick_idx_s;
                        rr_ptr_r    <= ptr_next_s;
                        state_r     <= DRIVE;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                DRIVE: begin
                    hold_r <= drive_s;
                    if (!req[owner_r]) begin
                        if (TURNAROUND > 0) begin
                            grant_r     <= '0;
                            bus_valid_r <= 1'b0;
                            cnt_r       <= 3'(TURNAROUND - 1);
                            state_r     <= TURN;
                        end else if (pick_hit_s) begin
                            // Zero-gap handover: the next owner takes the bus at the release edge.
                            grant_r     <= onehot_s;
                            bus_valid_r <= 1'b1;
                            owner_r     <= pick_idx_s;
                            rr_ptr_r    <= ptr_next_s;
                            state_r     <= DRIVE;
                        end else begin
                            grant_r     <= '0;
                            bus_valid_r <= 1'b0;
                            state_r     <= IDLE;
                        end
                    end else begin
                        state_r <= DRIVE;
                    end
                end
                TURN: begin
                    if (cnt_r == 3'd0) begin
                        if (pick_hit_s) begin
                            grant_r     <= onehot_s;
                            bus_valid_r <= 1'b1;
                            owner_r     <= pick_idx_s;
                            rr_ptr_r    <= ptr_next_s;
                            state_r     <= DRIVE;
                        end else begin
                            state_r     <= IDLE;
                        end
                    end else begin
                        cnt_r <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    grant_r     <= '0;
                    bus_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_driver.sv
// Bench for bus_arbiter_driver: directed vector table, corner-case sequences on
// three parameterisations, and randomized traffic against a reference model.
module tb_bus_arbiter_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: WIDTH=8, NUM_SRC=4, TURNAROUND=1
    logic rst_a; logic [3:0] req_a; logic [31:0] din_a;
    logic [7:0] bus_a; logic [3:0] gr_a; logic val_a; logic [7:0] hold_a; logic [1:0] own_a;
    // Instance B: WIDTH=8, NUM_SRC=3, TURNAROUND=1
    logic rst_3; logic [2:0] req_3; logic [23:0] din_3;
    logic [7:0] bus_3; logic [2:0] gr_3; logic val_3; logic [7:0] hold_3; logic [1:0] own_3;
    // Instance C: WIDTH=8, NUM_SRC=4, TURNAROUND=0
    logic rst_0; logic [3:0] req_0; logic [31:0] din_0;
    logic [7:0] bus_0; logic [3:0] gr_0; logic val_0; logic [7:0] hold_0; logic [1:0] own_0;

    bus_arbiter_driver #(.WIDTH(8), .NUM_SRC(4), .TURNAROUND(1)) dut_a (
        .clk(clk), .reset(rst_a), .req(req_a), .data_in(din_a), .bus_out(bus_a),
        .grant(gr_a), .bus_valid(val_a), .hold_data(hold_a), .owner(own_a));
    bus_arbiter_driver #(.WIDTH(8), .NUM_SRC(3), .TURNAROUND(1)) dut_3 (
        .clk(clk), .reset(rst_3), .req(req_3), .data_in(din_3), .bus_out(bus_3),
        .grant(gr_3), .bus_valid(val_3), .hold_data(hold_3), .owner(own_3));
    bus_arbiter_driver #(.WIDTH(8), .NUM_SRC(4), .TURNAROUND(0)) dut_0 (
        .clk(clk), .reset(rst_0), .req(req_0), .data_in(din_0), .bus_out(bus_0),
        .grant(gr_0), .bus_valid(val_0), .hold_data(hold_0), .owner(own_0));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // own: current owner (-1 = bus floating); gap: floating cycles still owed before arbitrating.
    typedef struct {
        int         own;
        int         last;
        int         gap;
        int         ptr;
        logic [7:0] hold;
    } mdl_t;

    function automatic mdl_t m_reset();
        mdl_t m;
        m.own = -1; m.last = 0; m.gap = 0; m.ptr = 0; m.hold = 8'h00;
        return m;
    endfunction

    function automatic mdl_t m_arb(mdl_t m, logic [3:0] r, int n);
        for (int i = 0; i < n; i++) begin
            int k;
            k = (m.ptr + i) % n;
            if (r[k]) begin
                m.own = k; m.last = k; m.ptr = (k + 1) % n;
                return m;
            end
        end
        return m;
    endfunction

    function automatic mdl_t m_step(mdl_t m, logic rst, logic [3:0] r, logic [31:0] d, int n, int t);
        if (rst) return m_reset();
        if (m.own >= 0) begin
            m.hold = 8'(d >> (8 * m.own));
            if (!r[m.own]) begin
                m.own = -1;
                m.gap = t;
                if (t == 0) m = m_arb(m, r, n);
            end
        end else begin
            if (m.gap > 0) m.gap--;
            if (m.gap == 0) m = m_arb(m, r, n);
        end
        return m;
    endfunction

    function automatic logic [31:0] exp_grant(mdl_t m);
        return (m.own >= 0) ? (32'd1 << m.own) : 32'd0;
    endfunction

    task automatic chk_model(input string nm, input mdl_t m, input logic [3:0] g, input logic v,
                             input logic [1:0] o, input logic [7:0] h, input logic [7:0] b,
                             input logic [31:0] d);
        chk({nm, ".grant"}, {28'd0, g}, exp_grant(m));
        chk({nm, ".valid"}, {31'd0, v}, {31'd0, (m.own >= 0)});
        chk({nm, ".owner"}, {30'd0, o}, 32'(m.last));
        chk({nm, ".hold"},  {24'd0, h}, {24'd0, m.hold});
        if (m.own >= 0) chk({nm, ".bus"}, {24'd0, b}, {24'd0, 8'(d >> (8 * m.own))});
    endtask

    function automatic logic [3:0] flip(input logic [3:0] r);
        logic [3:0] x;
        x = r;
        for (int i = 0; i < 4; i++) if ($urandom_range(3) == 0) x[i] = ~x[i];
        return x;
    endfunction

    // ---------------- directed vector table (instance A) ----------------
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  g;
        logic        v;
        logic [1:0]  own;
        logic [7:0]  hold;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rs, logic [3:0] r, logic [31:0] d, logic [3:0] g,
                                logic v, logic [1:0] o, logic [7:0] h);
        vec_t x;
        x.rst = rs; x.req = r; x.data = d; x.g = g; x.v = v; x.own = o; x.hold = h;
        return x;
    endfunction

    mdl_t ma, m3, m0;

    initial begin
        rst_a = 1'b1; req_a = '0; din_a = '0;
        rst_3 = 1'b1; req_3 = '0; din_3 = '0;
        rst_0 = 1'b1; req_0 = '0; din_0 = '0;

        // reset + idle
        tbl.push_back(mk(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0, 2'd0, 8'h00));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 4'b0000, 32'h0, 4'b0000, 1'b0, 2'd0, 8'h00));
        // single request, four cycles, then release
        tbl.push_back(mk(1'b0, 4'b0001, 32'hAA, 4'b0001, 1'b1, 2'd0, 8'h00));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 4'b0001, 32'hAA, 4'b0001, 1'b1, 2'd0, 8'hAA));
        tbl.push_back(mk(1'b0, 4'b0000, 32'hAA, 4'b0000, 1'b0, 2'd0, 8'hAA));
        tbl.push_back(mk(1'b0, 4'b0000, 32'hAA, 4'b0000, 1'b0, 2'd0, 8'hAA));
        // contention with one floating cycle between owners
        tbl.push_back(mk(1'b1, 4'b0000, 32'h44332211, 4'b0000, 1'b0, 2'd0, 8'h00));
        tbl.push_back(mk(1'b0, 4'b1111, 32'h44332211, 4'b0001, 1'b1, 2'd0, 8'h00));
        tbl.push_back(mk(1'b0, 4'b1111, 32'h44332211, 4'b0001, 1'b1, 2'd0, 8'h11));
        tbl.push_back(mk(1'b0, 4'b1110, 32'h44332211, 4'b0000, 1'b0, 2'd0, 8'h11));
        tbl.push_back(mk(1'b0, 4'b1110, 32'h44332211, 4'b0010, 1'b1, 2'd1, 8'h11));
        tbl.push_back(mk(1'b0, 4'b1110, 32'h44332211, 4'b0010, 1'b1, 2'd1, 8'h22));
        tbl.push_back(mk(1'b0, 4'b1100, 32'h44332211, 4'b0000, 1'b0, 2'd1, 8'h22));
        tbl.push_back(mk(1'b0, 4'b1100, 32'h44332211, 4'b0100, 1'b1, 2'd2, 8'h22));
        tbl.push_back(mk(1'b0, 4'b1100, 32'h44332211, 4'b0100, 1'b1, 2'd2, 8'h33));
        tbl.push_back(mk(1'b0, 4'b1000, 32'h44332211, 4'b0000, 1'b0, 2'd2, 8'h33));
        tbl.push_back(mk(1'b0, 4'b1000, 32'h44332211, 4'b1000, 1'b1, 2'd3, 8'h33));
        tbl.push_back(mk(1'b0, 4'b1000, 32'h44332211, 4'b1000, 1'b1, 2'd3, 8'h44));
        tbl.push_back(mk(1'b0, 4'b0000, 32'h44332211, 4'b0000, 1'b0, 2'd3, 8'h44));
        tbl.push_back(mk(1'b0, 4'b0000, 32'h44332211, 4'b0000, 1'b0, 2'd3, 8'h44));

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_a = tbl[i].rst; req_a = tbl[i].req; din_a = tbl[i].data;
            @(posedge clk); #1;
            chk($sformatf("vec%0d.grant", i), {28'd0, gr_a},   {28'd0, tbl[i].g});
            chk($sformatf("vec%0d.valid", i), {31'd0, val_a},  {31'd0, tbl[i].v});
            chk($sformatf("vec%0d.owner", i), {30'd0, own_a},  {30'd0, tbl[i].own});
            chk($sformatf("vec%0d.hold", i),  {24'd0, hold_a}, {24'd0, tbl[i].hold});
            if (tbl[i].v) chk($sformatf("vec%0d.bus", i), {24'd0, bus_a},
                              {24'd0, 8'(tbl[i].data >> (8 * int'(tbl[i].own)))});
        end

        // ---------------- pointer wrap with NUM_SRC=3 ----------------
        @(negedge clk); rst_3 = 1'b0; req_3 = 3'b100; din_3 = 24'h332211;
        @(posedge clk); #1 chk("wrap.first", {29'd0, gr_3}, 32'b100);
        @(negedge clk); req_3 = 3'b000;
        @(posedge clk); #1 chk("wrap.release", {29'd0, gr_3}, 32'b000);
        @(negedge clk); req_3 = 3'b101;
        @(posedge clk); #1 chk("wrap.to0", {29'd0, gr_3}, 32'b001);
        chk("wrap.bus0", {24'd0, bus_3}, 32'h11);
        @(negedge clk); req_3 = 3'b100;
        @(posedge clk); #1 chk("wrap.rel0", {29'd0, gr_3}, 32'b000);
        @(posedge clk); #1 chk("wrap.then2", {29'd0, gr_3}, 32'b100);
        chk("wrap.owner", {30'd0, own_3}, 32'd2);

        // ---------------- zero turnaround, data tracking, mid-op reset ----------------
        @(negedge clk); rst_0 = 1'b0; req_0 = 4'b0011; din_0 = 32'h00002211;
        @(posedge clk); #1 chk("zt.g0", {28'd0, gr_0}, 32'b0001);
        @(negedge clk); req_0 = 4'b0010;
        @(posedge clk); #1 chk("zt.g1_nogap", {28'd0, gr_0}, 32'b0010);
        chk("zt.valid", {31'd0, val_0}, 32'd1);
        chk("zt.hold11", {24'd0, hold_0}, 32'h11);
        @(negedge clk); din_0 = 32'h00005511;
        #1 chk("zt.bus55", {24'd0, bus_0}, 32'h55);
        #1 din_0 = 32'h00006611;
        #1 chk("zt.bus66", {24'd0, bus_0}, 32'h66);
        @(posedge clk); #1 chk("zt.hold66", {24'd0, hold_0}, 32'h66);
        @(negedge clk); rst_0 = 1'b1;
        @(posedge clk); #1 chk("zt.rst_grant", {28'd0, gr_0}, 32'd0);
        chk("zt.rst_valid", {31'd0, val_0}, 32'd0);
        chk("zt.rst_hold", {24'd0, hold_0}, 32'd0);

        // ---------------- randomized traffic vs model ----------------
        @(negedge clk); rst_a = 1'b1; rst_3 = 1'b1; rst_0 = 1'b1;
        req_a = '0; req_3 = '0; req_0 = '0;
        @(posedge clk);
        ma = m_reset(); m3 = m_reset(); m0 = m_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            rst_a = ($urandom_range(63) == 0);
            rst_3 = ($urandom_range(63) == 0);
            rst_0 = ($urandom_range(63) == 0);
            req_a = flip(req_a);
            req_3 = 3'(flip({1'b0, req_3}));
            req_0 = flip(req_0);
            din_a = $urandom; din_3 = 24'($urandom); din_0 = $urandom;
            #1;
            if (ma.own >= 0) chk("rnd_a.bus_pre", {24'd0, bus_a}, {24'd0, 8'(din_a >> (8 * ma.own))});
            if (m0.own >= 0) chk("rnd_0.bus_pre", {24'd0, bus_0}, {24'd0, 8'(din_0 >> (8 * m0.own))});
            @(posedge clk);
            ma = m_step(ma, rst_a, req_a, din_a, 4, 1);
            m3 = m_step(m3, rst_3, {1'b0, req_3}, {8'd0, din_3}, 3, 1);
            m0 = m_step(m0, rst_0, req_0, din_0, 4, 0);
            #1;
            chk_model("rnd_a", ma, gr_a, val_a, own_a, hold_a, bus_a, din_a);
            chk_model("rnd_3", m3, {1'b0, gr_3}, val_3, own_3, hold_3, bus_3, {8'd0, din_3});
            chk_model("rnd_0", m0, gr_0, val_0, own_0, hold_0, bus_0, din_0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
